// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single GPR write port among core writeback,
// memory (load) writeback and debug writes. Core writeback always wins and
// never stalls. Memory and debug use valid/ready handshakes. Debug carries an
// age counter so a steady stream of memory writebacks cannot lock it out.
// The write port outputs are registered, one cycle after acceptance.
module rf_wr_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wr_en_i,
  input  logic [ADDR_W-1:0] core_wr_addr_i,
  input  logic [DATA_W-1:0] core_wr_data_i,
  input  logic              mem_valid_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  input  logic              dbg_valid_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_data_i,
  output logic              dbg_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [1:0]        grant_src_o,
  output logic              dbg_starve_o
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CORE = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_DBG  = 2'd3
  } src_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  src_e              win;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [CNT_W-1:0]  age_cnt;
  logic [CNT_W-1:0]  age_cnt_next;
  logic              starve_q;

  // Select this cycle's winner: core, then a starved debug, then mem, then debug.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    win      = SRC_NONE;
    win_addr = '0;
    win_data = '0;
    if (core_wr_en_i) begin
      win      = SRC_CORE;
      win_addr = core_wr_addr_i;
      win_data = core_wr_data_i;
    end else if (dbg_valid_i && starve_q) begin
      win      = SRC_DBG;
      win_addr = dbg_addr_i;
      win_data = dbg_data_i;
    end else if (mem_valid_i) begin
      win      = SRC_MEM;
      win_addr = mem_addr_i;
      win_data = mem_data_i;
    end else if (dbg_valid_i) begin
      win      = SRC_DBG;
      win_addr = dbg_addr_i;
      win_data = dbg_data_i;
    end
  end

  // Readies follow the winner and are held low during a reset cycle so
  // nothing is accepted while the output registers are being cleared.
  assign mem_ready_o  = rst_n && (win == SRC_MEM);
  assign dbg_ready_o  = rst_n && (win == SRC_DBG);
  assign dbg_starve_o = starve_q;

  // Next age value: count stalled debug cycles (saturating), clear otherwise.
  always_comb begin
    age_cnt_next = '0;
    if (dbg_valid_i && !dbg_ready_o) begin
      age_cnt_next = (age_cnt == CNT_MAX) ? age_cnt : age_cnt + CNT_W'(1);
    end
  end

  // Age counter and its registered starvation flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_cnt  <= '0;
      starve_q <= 1'b0;
    end else begin
      age_cnt  <= age_cnt_next;
      starve_q <= (age_cnt_next >= CNT_LIMIT);
    end
  end

  // Registered write port; address/data hold when there is no winner and
  // writes to x0 are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      grant_src_o <= SRC_NONE;
    end else begin
      wr_en_o     <= (win != SRC_NONE) && (win_addr != '0);
      grant_src_o <= win;
      if (win != SRC_NONE) begin
        wr_addr_o <= win_addr;
        wr_data_o <= win_data;
      end
    end
  end

endmodule
